// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/full generator for an asynchronous FIFO: binary and Gray write
// pointers, 2-flop read-pointer synchronizer, registered full/overflow (almost_full with FIFO_ALMOST_FULL_EN).
module fifo_wptr_full #(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                     w_clk,
  input  logic                     w_rst_n,
  input  logic                     wr_rq,
  input  logic [$clog2(DEPTH):0]   rptr_gray,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [$clog2(DEPTH):0]   wptr_gray,
  output logic                     full,
  output logic                     wr_ovf
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                     almost_full
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_MARGIN < 1) || (AF_MARGIN >= DEPTH))
  begin : g_bad_param
    $error("fifo_wptr_full: DEPTH must be a power of two >= 4 and AF_MARGIN in 1..DEPTH-1");
  end

  logic              wr_inc;
  logic [ADDR_W:0]   wbin_d, wbin_q;
  logic [ADDR_W:0]   wgray_d, wgray_q;
  logic [ADDR_W:0]   rq1_d, rq1_q;
  logic [ADDR_W:0]   rq2_d, rq2_q;
  logic [ADDR_W:0]   full_target;
  logic              full_d, full_q;
  logic              wr_ovf_d, wr_ovf_q;

  always_comb begin
    wr_inc      = wr_rq && !full_q;
    wbin_d      = wbin_q + {{ADDR_W{1'b0}}, wr_inc};
    wgray_d     = wbin_d ^ (wbin_d >> 1);
    rq1_d       = rptr_gray;
    rq2_d       = rq1_q;
    // Full when the next write pointer is exactly one lap ahead of the synchronized read pointer.
    full_target = {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]};
    full_d      = (wgray_d == full_target);
    wr_ovf_d    = wr_ovf_q || (wr_rq && full_q);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rq1_q    <= '0;
      rq2_q    <= '0;
      full_q   <= 1'b0;
      wr_ovf_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rq1_q    <= rq1_d;
      rq2_q    <= rq2_d;
      full_q   <= full_d;
      wr_ovf_q <= wr_ovf_d;
    end
  end

  assign waddr     = wbin_q[ADDR_W-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign wr_ovf    = wr_ovf_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] level_next;
  logic            almost_full_d, almost_full_q;

  always_comb begin
    rbin_s = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 0; i <= ADDR_W; i++) begin
      rbin_s[i] = ^(rq2_q >> i);
    end
    level_next    = wbin_d - rbin_s;
    almost_full_d = (level_next >= AF_THRESH);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized self-checking bench for fifo_wptr_full against a level-based occupancy model.
module tb_fifo_wptr_full;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int MODW  = 2 * DEPTH;

  logic          w_clk = 1'b0;
  logic          w_rst_n = 1'b0;
  logic          wr_rq = 1'b0;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          wr_ovf;
`ifdef FIFO_ALMOST_FULL_EN
  localparam int AF_MARGIN = 2;
  logic          almost_full;
  bit            m_af;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Model: write/read counts mod 2*DEPTH; read count seen after a 2-stage delay.
  int          m_wbin, m_rq1, m_rq2, rd_bin;
  bit          m_full, m_ovf;
  logic [AW:0] prev_gray;
  bit          wrap_seen;

  fifo_wptr_full #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (2)
  ) dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .wr_rq     (wr_rq),
    .rptr_gray (rptr_gray),
    .waddr     (waddr),
    .wptr_gray (wptr_gray),
    .full      (full),
    .wr_ovf    (wr_ovf)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  assign rptr_gray = to_gray(rd_bin);

  task automatic model_reset();
    m_wbin = 0; m_rq1 = 0; m_rq2 = 0; rd_bin = 0;
    m_full = 0; m_ovf = 0;
`ifdef FIFO_ALMOST_FULL_EN
    m_af = 0;
`endif
  endtask

  // Advance the model with the current inputs, then let the DUT take one edge.
  task automatic tick();
    int inc, nb, lvl;
    inc = (wr_rq && !m_full) ? 1 : 0;
    nb  = (m_wbin + inc) % MODW;
    lvl = (nb - m_rq2 + MODW) % MODW;
    m_ovf  = m_ovf || (wr_rq && m_full);
    m_full = (lvl == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
    m_af   = (lvl >= DEPTH - AF_MARGIN);
`endif
    m_wbin = nb;
    m_rq2  = m_rq1;
    m_rq1  = rd_bin;
    prev_gray = wptr_gray;
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst_n = 1'b0;
    wr_rq   = 1'b0;
    model_reset();
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (waddr !== 4'd0) $display("FAIL reset_waddr got %0d want 0", waddr); else n_pass++;
    n_total++;
    if (wptr_gray !== 5'd0) $display("FAIL reset_gray got %b want 00000", wptr_gray); else n_pass++;
    n_total++;
    if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_total++;
    if (wr_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", wr_ovf); else n_pass++;
`ifdef FIFO_ALMOST_FULL_EN
    n_total++;
    if (almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full); else n_pass++;
`endif
  endtask

  task automatic test_fill();
    wr_rq = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (waddr !== i[AW-1:0]) $display("FAIL fill_waddr got %0d want %0d", waddr, i); else n_pass++;
      tick();
      n_total++;
      if (wptr_gray !== to_gray(i + 1)) $display("FAIL fill_gray got %b want %b", wptr_gray, to_gray(i + 1));
      else n_pass++;
      n_total++;
      if (full !== (i == DEPTH - 1)) $display("FAIL fill_full edge %0d got %b want %b", i + 1, full, i == DEPTH - 1);
      else n_pass++;
    end
    n_total++;
    if (wptr_gray !== 5'b11000) $display("FAIL fill_gray_end got %b want 11000", wptr_gray); else n_pass++;
    n_total++;
    if (waddr !== 4'd0) $display("FAIL fill_waddr_end got %0d want 0", waddr); else n_pass++;
  endtask

  task automatic test_blocked();
    wr_rq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (wptr_gray !== 5'b11000) $display("FAIL blocked_gray got %b want 11000", wptr_gray); else n_pass++;
      n_total++;
      if (wr_ovf !== 1'b1) $display("FAIL blocked_ovf got %b want 1", wr_ovf); else n_pass++;
      n_total++;
      if (full !== 1'b1) $display("FAIL blocked_full got %b want 1", full); else n_pass++;
    end
  endtask

  task automatic test_release();
    wr_rq  = 1'b0;
    rd_bin = 1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_total++;
      if (full !== (e < 3)) $display("FAIL release_full edge %0d got %b want %b", e, full, e < 3); else n_pass++;
    end
    wr_rq = 1'b1;
    n_total++;
    if (waddr !== 4'd0) $display("FAIL release_waddr got %0d want 0", waddr); else n_pass++;
    tick();
    wr_rq = 1'b0;
    n_total++;
    if (wptr_gray !== to_gray(17)) $display("FAIL release_gray got %b want %b", wptr_gray, to_gray(17));
    else n_pass++;
    n_total++;
    if (full !== 1'b1) $display("FAIL release_refull got %b want 1", full); else n_pass++;
  endtask

  task automatic test_random();
    wrap_seen = 0;
    for (int c = 0; c < 400; c++) begin
      int lvl;
      wr_rq = ($urandom_range(0, 3) != 0);
      lvl = (m_wbin - rd_bin + MODW) % MODW;
      if (lvl > 0 && ($urandom_range(0, 3) < ((c < 200) ? 1 : 3))) rd_bin = (rd_bin + 1) % MODW;
      tick();
      if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) wrap_seen = 1;
      n_total++;
      if (waddr !== m_wbin[AW-1:0]) $display("FAIL rand_waddr cyc %0d got %0d want %0d", c, waddr, m_wbin[AW-1:0]);
      else n_pass++;
      n_total++;
      if (wptr_gray !== to_gray(m_wbin)) $display("FAIL rand_gray cyc %0d got %b want %b", c, wptr_gray, to_gray(m_wbin));
      else n_pass++;
      n_total++;
      if ($countones(wptr_gray ^ prev_gray) > 1)
        $display("FAIL rand_gray_step cyc %0d got %b after %b want at most 1 bit change", c, wptr_gray, prev_gray);
      else n_pass++;
      n_total++;
      if (full !== m_full) $display("FAIL rand_full cyc %0d got %b want %b", c, full, m_full); else n_pass++;
      n_total++;
      if (wr_ovf !== m_ovf) $display("FAIL rand_ovf cyc %0d got %b want %b", c, wr_ovf, m_ovf); else n_pass++;
`ifdef FIFO_ALMOST_FULL_EN
      n_total++;
      if (almost_full !== m_af) $display("FAIL rand_af cyc %0d got %b want %b", c, almost_full, m_af); else n_pass++;
`endif
    end
    wr_rq = 1'b0;
    n_total++;
    if (wrap_seen !== 1'b1) $display("FAIL rand_wrap got %b want 1 (10000->00000 seen)", wrap_seen); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_rq = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    wr_rq = 1'b0;
    n_total++;
    if (waddr !== 4'd9 || full !== 1'b0) $display("FAIL areset_pre got waddr %0d full %b want 9 0", waddr, full);
    else n_pass++;
    #3;
    w_rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (waddr !== 4'd0) $display("FAIL areset_waddr got %0d want 0", waddr); else n_pass++;
    n_total++;
    if (wptr_gray !== 5'd0) $display("FAIL areset_gray got %b want 00000", wptr_gray); else n_pass++;
    n_total++;
    if (full !== 1'b0 || wr_ovf !== 1'b0) $display("FAIL areset_flags got full %b ovf %b want 0 0", full, wr_ovf);
    else n_pass++;
    #2;
    w_rst_n = 1'b1;
    tick();
    wr_rq = 1'b1;
    n_total++;
    if (waddr !== 4'd0) $display("FAIL areset_first_waddr got %0d want 0", waddr); else n_pass++;
    tick();
    wr_rq = 1'b0;
    n_total++;
    if (waddr !== 4'd1) $display("FAIL areset_second_waddr got %0d want 1", waddr); else n_pass++;
  endtask

`ifdef FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    wr_rq = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      n_total++;
      if (almost_full !== (k >= 14)) $display("FAIL af_level %0d got %b want %b", k, almost_full, k >= 14);
      else n_pass++;
      n_total++;
      if (full !== (k == DEPTH)) $display("FAIL af_full %0d got %b want %b", k, full, k == DEPTH); else n_pass++;
    end
    wr_rq = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_blocked();
    test_release();
    test_random();
    test_async_reset();
`ifdef FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
